// File: rtl/hypot_seq_ctrl.sv
// Sequencer computing floor(sqrt(x^2+y^2)) with one shared serial shift-add squarer.
// Fixed latency: done pulses 109 cycles after start accept; start ignored while busy.
module hypot_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [W:0]     result,
  output logic [2*W:0]   sum_sq
);

  localparam int OW = W + 1;
  localparam int PW = 2 * W + 2;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQX,
    S_SQY,
    S_RSQ,
    S_RCMP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;

  logic [W-1:0]    y_q;
  logic [OW-1:0]   sq_op_q;
  logic [OW-1:0]   sq_mpr_q;
  logic [PW-1:0]   sq_mcd_q;
  logic [PW-1:0]   sq_acc_q;
  logic [CW-1:0]   sq_cnt_q;
  logic [2*W:0]    sum_q;
  logic [OW-1:0]   root_q;
  logic [CW-1:0]   bit_q;

  logic            sq_run;
  logic            sq_last;
  logic [PW-1:0]   sq_add;
  logic [PW-1:0]   sq_prod;
  logic            fits;
  logic [OW-1:0]   root_nxt;
  logic [CW-1:0]   bit_dec;
  logic [OW-1:0]   trial_nxt;

  logic            sq_ld;
  logic [OW-1:0]   sq_ld_val;
  logic            lat_y;
  logic            sum_ld;
  logic            sum_add;
  logic            root_clr;
  logic            root_upd;
  logic            out_upd;

  // sq_prod is the accumulator value after this cycle's shift-add step;
  // on the last step it is the complete square.
  assign sq_run    = (state_q == S_SQX) || (state_q == S_SQY) || (state_q == S_RSQ);
  assign sq_last   = (sq_cnt_q == CW'(W));
  assign sq_add    = sq_mpr_q[0] ? sq_mcd_q : '0;
  assign sq_prod   = sq_acc_q + sq_add;

  // In RCMP the accumulator holds t^2 and sq_op_q still holds t.
  assign fits      = (sq_acc_q <= {1'b0, sum_q});
  assign root_nxt  = fits ? sq_op_q : root_q;
  assign bit_dec   = bit_q - CW'(1);
  assign trial_nxt = root_nxt | (OW'(1) << bit_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sq_ld     = 1'b0;
    sq_ld_val = '0;
    lat_y     = 1'b0;
    sum_ld    = 1'b0;
    sum_add   = 1'b0;
    root_clr  = 1'b0;
    root_upd  = 1'b0;
    out_upd   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          sq_ld     = 1'b1;
          sq_ld_val = {1'b0, x};
          lat_y     = 1'b1;
          state_d   = S_SQX;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SQX: begin
        busy = 1'b1;
        if (sq_last) begin
          sum_ld    = 1'b1;
          sq_ld     = 1'b1;
          sq_ld_val = {1'b0, y_q};
          state_d   = S_SQY;
        end
      end
      S_SQY: begin
        busy = 1'b1;
        if (sq_last) begin
          sum_add   = 1'b1;
          root_clr  = 1'b1;
          sq_ld     = 1'b1;
          sq_ld_val = OW'(1) << W;
          state_d   = S_RSQ;
        end
      end
      S_RSQ: begin
        busy = 1'b1;
        if (sq_last) begin
          state_d = S_RCMP;
        end
      end
      S_RCMP: begin
        busy     = 1'b1;
        root_upd = 1'b1;
        if (bit_q == '0) begin
          out_upd = 1'b1;
          state_d = S_DONE;
        end else begin
          sq_ld     = 1'b1;
          sq_ld_val = trial_nxt;
          state_d   = S_RSQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      sq_op_q  <= '0;
      sq_mpr_q <= '0;
      sq_mcd_q <= '0;
      sq_acc_q <= '0;
      sq_cnt_q <= '0;
      sum_q    <= '0;
      root_q   <= '0;
      bit_q    <= '0;
      result   <= '0;
      sum_sq   <= '0;
    end else begin
      if (lat_y) begin
        y_q <= y;
      end

      // A load overrides the step: the finished product has already been
      // consumed through sq_prod in the same cycle.
      if (sq_ld) begin
        sq_op_q  <= sq_ld_val;
        sq_mpr_q <= sq_ld_val;
        sq_mcd_q <= {{(PW-OW){1'b0}}, sq_ld_val};
        sq_acc_q <= '0;
        sq_cnt_q <= '0;
      end else if (sq_run) begin
        sq_acc_q <= sq_prod;
        sq_mpr_q <= sq_mpr_q >> 1;
        sq_mcd_q <= sq_mcd_q << 1;
        sq_cnt_q <= sq_cnt_q + CW'(1);
      end

      if (sum_ld) begin
        sum_q <= sq_prod[2*W:0];
      end else if (sum_add) begin
        sum_q <= sum_q + sq_prod[2*W:0];
      end

      if (root_clr) begin
        root_q <= '0;
        bit_q  <= CW'(W);
      end else if (root_upd) begin
        root_q <= root_nxt;
        if (bit_q != '0) begin
          bit_q <= bit_dec;
        end
      end

      if (out_upd) begin
        result <= root_nxt;
        sum_sq <= sum_q;
      end
    end
  end

endmodule

// File: tb/tb_hypot_seq_ctrl.sv
// Randomized and directed bench for hypot_seq_ctrl against an arithmetic reference.
module tb_hypot_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        done;
  logic [8:0]  result;
  logic [16:0] sum_sq;

  int checks = 0;
  int errors = 0;

  hypot_seq_ctrl #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .result (result),
    .sum_sq (sum_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // One job: start pulsed for one cycle, optional start poke while busy at T+40.
  task automatic run_job(input logic [7:0] xv, input logic [7:0] yv, input bit poke,
                         input string tag);
    int bad;
    int exp_s;
    int exp_r;
    exp_s = int'(xv) * int'(xv) + int'(yv) * int'(yv);
    exp_r = isqrt(exp_s);
    @(negedge clk);
    start = 1'b1; x = xv; y = yv;
    @(posedge clk);
    #1;
    start = 1'b0; x = 8'($urandom); y = 8'($urandom);
    bad = 0;
    for (int k = 1; k <= 108; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (poke && k == 40) begin start = 1'b1; x = 8'd9; y = 8'd12; end
      if (poke && k == 41) begin start = 1'b0; x = 8'd77; end
    end
    chk({tag, "_busy_window"}, bad, 0);
    @(negedge clk);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_in_done"}, int'(busy), 0);
    chk({tag, "_result"}, int'(result), exp_r);
    chk({tag, "_sum_sq"}, int'(sum_sq), exp_s);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, int'(done), 0);
    chk({tag, "_result_hold"}, int'(result), exp_r);
  endtask

  initial begin
    int bad;
    int dcnt;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    #23;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_sum_sq", int'(sum_sq), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_job(8'd3, 8'd4, 1'b0, "j34");
    run_job(8'd255, 8'd255, 1'b0, "jmax");
    run_job(8'd0, 8'd0, 1'b0, "jzero");
    run_job(8'd1, 8'd1, 1'b0, "j11");

    // Start poke while busy must be ignored, with no second done afterwards.
    run_job(8'd6, 8'd8, 1'b1, "jpoke");
    dcnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("poke_no_second_job", dcnt, 0);

    // Start held high: a job completes every 109 cycles.
    @(negedge clk);
    start = 1'b1; x = 8'd5; y = 8'd12;
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      bad = 0;
      for (int k = 1; k <= 108; k++) begin
        @(negedge clk);
        if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      chk("held_busy_window", bad, 0);
      @(negedge clk);
      chk("held_done", int'(done), 1);
      chk("held_busy_in_done", int'(busy), 0);
      chk("held_result", int'(result), 13);
      chk("held_sum_sq", int'(sum_sq), 169);
      if (j == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("held_release_busy", int'(busy), 0);

    // Reset in mid-job clears everything and discards the job.
    @(negedge clk);
    start = 1'b1; x = 8'd200; y = 8'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_sum_sq", int'(sum_sq), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("post_rst_quiet", dcnt, 0);
    run_job(8'd7, 8'd24, 1'b0, "j724");

    for (int i = 0; i < 16; i++) begin
      run_job(8'($urandom), 8'($urandom), i[0], "rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
